// File: rtl/branch_predictor_gshare.sv
// Gshare direction predictor with a direct-mapped BTB. The prediction is combinational from PC;
// resolved jal/jalr/branch outcomes train the BTB, the PHT counters and the global history.
module branch_predictor_gshare #(
  parameter int unsigned XLEN      = 64,
  parameter int unsigned IDX_BITS  = 6,
  parameter int unsigned HIST_BITS = 6,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned TAG_BITS  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] PC,
  input  logic [XLEN-1:0] PCPlus4,
  input  logic            we,
  input  logic [XLEN-1:0] PCUpdate,
  input  logic [XLEN-1:0] targetUpdate,
  input  logic            takenUpdate,
  input  logic            isCond,
  input  logic            clear,
  output logic [XLEN-1:0] PCPrediction,
  output logic            predTaken,
  output logic            btbHit
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam int unsigned GH_W    = (HIST_BITS > 0) ? HIST_BITS : 1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  logic [ENTRIES-1:0]  valid;
  logic [ENTRIES-1:0]  btbUncond;
  logic [TAG_BITS-1:0] btbTag    [ENTRIES];
  logic [XLEN-1:0]     btbTarget [ENTRIES];
  logic [CTR_BITS-1:0] pht       [ENTRIES];
  logic [GH_W-1:0]     ghr;

  logic [IDX_BITS-1:0] histIdx;
  logic [IDX_BITS-1:0] fetchIdx;
  logic [IDX_BITS-1:0] fetchPidx;
  logic [IDX_BITS-1:0] updIdx;
  logic [IDX_BITS-1:0] updPidx;
  logic [CTR_BITS-1:0] ctrCur;
  logic [CTR_BITS-1:0] ctrNext;
  logic                unusedBits;

  function automatic logic [IDX_BITS-1:0] bidxOf(input logic [XLEN-1:0] a);
    return a[IDX_BITS+1:2];
  endfunction

  function automatic logic [TAG_BITS-1:0] tagOf(input logic [XLEN-1:0] a);
    return a[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
  endfunction

  // A zero-length history degenerates to bimodal: the GHR never reaches the index.
  assign histIdx   = (HIST_BITS == 0) ? '0 : IDX_BITS'(ghr);
  assign fetchIdx  = bidxOf(PC);
  assign fetchPidx = fetchIdx ^ histIdx;
  assign updIdx    = bidxOf(PCUpdate);
  assign updPidx   = updIdx ^ histIdx;
  assign unusedBits = ^{PC, PCUpdate};

  always_comb begin
    btbHit       = valid[fetchIdx] && (btbTag[fetchIdx] == tagOf(PC));
    predTaken    = btbHit && (btbUncond[fetchIdx] || pht[fetchPidx][CTR_BITS-1]);
    PCPrediction = predTaken ? btbTarget[fetchIdx] : PCPlus4;
  end

  always_comb begin
    ctrCur  = pht[updPidx];
    ctrNext = ctrCur;
    if (takenUpdate && (ctrCur != '1))
      ctrNext = ctrCur + 1'b1;
    else if (!takenUpdate && (ctrCur != '0))
      ctrNext = ctrCur - 1'b1;
  end

  // Payload needs no reset: an entry is only observable once its valid bit is set.
  always_ff @(posedge clk) begin
    if (we && takenUpdate && !clear) begin
      btbTag[updIdx]    <= tagOf(PCUpdate);
      btbTarget[updIdx] <= targetUpdate;
      btbUncond[updIdx] <= ~isCond;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) pht[i] <= CTR_INIT;
      ghr <= '0;
    end else if (clear) begin
      valid <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) pht[i] <= CTR_INIT;
      ghr <= '0;
    end else if (we) begin
      if (takenUpdate) valid[updIdx] <= 1'b1;
      if (isCond) begin
        pht[updPidx] <= ctrNext;
        if (HIST_BITS > 0) ghr <= GH_W'({ghr, takenUpdate});
      end
    end
  end

endmodule

// File: doc/branch_predictor_gshare.md
BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

Interface
REQ-001 SHALL have parameter XLEN, default 64, meaning PC/target width in bits.
REQ-002 SHALL have parameter IDX_BITS, default 6, meaning log2 of table entries (PHT and BTB).
REQ-003 SHALL have parameter HIST_BITS, default 6, meaning global history length; legal 0..IDX_BITS; 0 gives a pure bimodal predictor.
REQ-004 SHALL have parameter CTR_BITS, default 2, meaning saturating counter width; legal 1..4.
REQ-005 SHALL have parameter TAG_BITS, default 8, meaning BTB tag width.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-008 SHALL have port PC, input, XLEN bits: fetch address being predicted.
REQ-009 SHALL have port PCPlus4, input, XLEN bits: fall-through address of PC.
REQ-010 SHALL have port we, input, 1 bit: a resolved jal/jalr/branch is presented this cycle.
REQ-011 SHALL have port PCUpdate, input, XLEN bits: address of the resolved instruction.
REQ-012 SHALL have port targetUpdate, input, XLEN bits: resolved target address.
REQ-013 SHALL have port takenUpdate, input, 1 bit: resolved direction.
REQ-014 SHALL have port isCond, input, 1 bit: 1 = conditional branch, 0 = jal/jalr.
REQ-015 SHALL have port clear, input, 1 bit: synchronous flush of all predictor state.
REQ-016 SHALL have port PCPrediction, output, XLEN bits: predicted next fetch address.
REQ-017 SHALL have port predTaken, output, 1 bit: prediction redirects away from PCPlus4.
REQ-018 SHALL have port btbHit, output, 1 bit: valid BTB entry whose tag matches PC.

Function
REQ-019 SHALL hold 2^IDX_BITS BTB entries {valid, tag, target[XLEN], uncond} and 2^IDX_BITS CTR_BITS-wide PHT counters, plus a HIST_BITS global history register (GHR).
REQ-020 SHALL use, for address A: bidx = A[IDX_BITS+1:2], tag = A[IDX_BITS+TAG_BITS+1:IDX_BITS+2], pidx = bidx XOR zero-extended GHR.
REQ-021 SHALL compute the prediction combinationally from PC in the same cycle (zero latency): btbHit = valid & tag match at bidx(PC).
REQ-022 SHALL set predTaken = btbHit & (uncond | counter MSB at pidx(PC)); PCPrediction = predTaken ? stored target : PCPlus4.
REQ-023 SHALL, on a rising edge with we=1 and takenUpdate=1, write BTB[bidx(PCUpdate)] = {1, tag(PCUpdate), targetUpdate, ~isCond}, replacing any previous occupant.
REQ-024 SHALL leave the BTB unchanged when we=1 and takenUpdate=0; the BTB never allocates on not-taken.
REQ-025 SHALL, when we=1 and isCond=1, increment PHT[pidx(PCUpdate)] if taken and decrement it otherwise, saturating at 2^CTR_BITS-1 and at 0. pidx uses the GHR value before this edge.
REQ-026 SHALL, on the same edge, shift the GHR left by one, inserting takenUpdate at bit 0 and dropping the MSB; the GHR is non-speculative.
REQ-027 SHALL NOT change PHT or GHR when isCond=0.
REQ-028 SHALL, for read-during-write (PC maps to the entry being updated), present pre-edge state during that cycle and new state from the next cycle.
REQ-029 SHALL give clear=1 priority over we in that cycle: all valid=0, all counters reset to the weakly-not-taken value, GHR=0.
REQ-030 SHALL have no state change when we=0 and clear=0.

Reset
REQ-031 SHALL, while reset=0, asynchronously force all valid=0, every counter to 2^(CTR_BITS-1)-1 (01 for CTR_BITS=2), and GHR=0.
REQ-032 SHALL therefore drive btbHit=0, predTaken=0 and PCPrediction=PCPlus4 during and immediately after reset, including when reset is asserted mid-operation.

Verification
REQ-033 SHALL cover bimodal training: HIST_BITS=0; one update with PCUpdate=0x100, targetUpdate=0x80, takenUpdate=1, isCond=1 -> fetch PC=0x100 gives btbHit=1, predTaken=1, PCPrediction=0x80.
REQ-034 SHALL cover saturation: after REQ-033, five not-taken updates of 0x100 followed by one taken update -> counter=01, PC=0x100 predicts 0x104 with btbHit=1.
REQ-035 SHALL cover unconditional entries and tag aliasing: a jal update at 0x200 with target 0x400 -> PC=0x200 predicts 0x400 and GHR is unchanged; then a taken update at 0x100 evicts the entry -> PC=0x200 gives btbHit=0 and PCPrediction=0x204.
REQ-036 SHALL cover gshare indexing: defaults; a taken cond update at 0x100 makes GHR=1 -> PC=0x100 reads PHT[1]=01, giving btbHit=1, predTaken=0, PCPrediction=0x104.
REQ-037 SHALL cover clear versus update: clear=1 and we=1 in the same cycle -> all entries invalid, GHR=0 next cycle.
REQ-038 SHALL cover asynchronous reset: reset pulsed low between clock edges after training -> PCPrediction=PCPlus4 immediately, without waiting for a clock edge.
